// File: rtl/instr_scheduler.sv
// rtl/instr_scheduler.sv - debounced instruction capture, FIFO queue and one-at-a-time issue sequencer
module instr_scheduler #(
    parameter int DEPTH        = 4,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   send,
    input  logic [17:0]            switches,
    output logic [17:0]            instr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic                   core_done,
    input  logic                   lcd_busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   full,
    output logic                   overflow,
    output logic [7:0]             issued_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
    state_t state, state_nxt;

    logic          send_s1, send_s2, send_db, push;
    logic [DW-1:0] db_cnt;
    logic [17:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          pop, push_ok, has_room;

    // Level must disagree with the debounced value for DEBOUNCE_CYC+1 straight cycles to flip it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            send_s1 <= 1'b0;
            send_s2 <= 1'b0;
            send_db <= 1'b0;
            db_cnt  <= '0;
            push    <= 1'b0;
        end else begin
            send_s1 <= send;
            send_s2 <= send_s1;
            push    <= 1'b0;
            if (send_s2 == send_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE_CYC)) begin
                db_cnt  <= '0;
                send_db <= send_s2;
                push    <= send_s2;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign has_room = (fifo_count < CW'(DEPTH));
    assign pop      = (state == ISSUE) && instr_ready;
    assign push_ok  = push && (has_room || pop);
    assign full     = (fifo_count == CW'(DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fifo_count   <= '0;
            overflow     <= 1'b0;
            issued_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr       <= rd_ptr + 1'b1;
                issued_count <= issued_count + 1'b1;
            end
            if (push_ok && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !push_ok)
                fifo_count <= fifo_count - 1'b1;
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

    // On a full push+pop the tail slot is the head being popped; the read is taken before the edge
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= switches;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        instr_valid = 1'b0;
        instr       = '0;
        case (state)
            IDLE: begin
                if (fifo_count != '0 && !lcd_busy) state_nxt = ISSUE;
            end
            ISSUE: begin
                instr_valid = 1'b1;
                instr       = mem[rd_ptr];
                if (instr_ready) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (core_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_instr_scheduler.sv
// tb/tb_instr_scheduler.sv - directed bench with a queue-based reference model for instr_scheduler
module tb_instr_scheduler;
    localparam int DEPTH = 4;
    localparam int D     = 16;

    logic        clk;
    logic        reset;
    logic        send;
    logic [17:0] switches;
    logic [17:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        core_done;
    logic        lcd_busy;
    logic [2:0]  fifo_count;
    logic        full;
    logic        overflow;
    logic [7:0]  issued_count;

    int checks = 0;
    int errors = 0;
    int valid_cycles = 0;
    logic [17:0] log_q[$];

    instr_scheduler #(.DEPTH(DEPTH), .DEBOUNCE_CYC(D)) dut (
        .clk(clk), .reset(reset), .send(send), .switches(switches),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .core_done(core_done), .lcd_busy(lcd_busy), .fifo_count(fifo_count),
        .full(full), .overflow(overflow), .issued_count(issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: queue of words, debounced level from a window of synchronized samples
    logic [17:0] mq[$];
    bit          hist[$];
    bit          m_offer, m_wait, m_ovf, m_pend, m_db, all_diff;
    int          m_issued, had;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            hist.delete();
            for (int i = 0; i < D + 3; i++) hist.push_back(1'b0);
            m_offer = 0; m_wait = 0; m_ovf = 0; m_pend = 0; m_db = 0; m_issued = 0;
        end else begin
            had = mq.size();
            if (m_offer && instr_ready) begin
                mq.delete(0);
                m_issued = (m_issued + 1) % 256;
            end
            if (m_pend) begin
                if (mq.size() < DEPTH) mq.push_back(switches);
                else m_ovf = 1;
            end
            m_pend = 0;
            hist.push_back(send);
            hist.delete(0);
            all_diff = 1;
            for (int i = 0; i <= D; i++) if (hist[i] == m_db) all_diff = 0;
            if (all_diff) begin
                m_db   = !m_db;
                m_pend = m_db;
            end
            if (m_wait) begin
                if (core_done) m_wait = 0;
            end else if (m_offer) begin
                if (instr_ready) begin
                    m_offer = 0;
                    m_wait  = 1;
                end
            end else if (had > 0 && !lcd_busy) begin
                m_offer = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("m_valid", 32'(instr_valid), 32'(m_offer));
            chk("m_instr", 32'(instr), m_offer ? 32'(mq[0]) : 32'h0);
            chk("m_count", 32'(fifo_count), 32'(mq.size()));
            chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
            chk("m_overflow", 32'(overflow), 32'(m_ovf));
            chk("m_issued", 32'(issued_count), 32'(m_issued));
        end
    end

    always @(negedge clk) begin
        if (!reset && instr_valid === 1'b1) begin
            valid_cycles++;
            if (instr_ready) log_q.push_back(instr);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [17:0] w);
        switches = w;
        send = 1'b1;
        step(D + 6);
        send = 1'b0;
        step(D + 6);
    endtask

    function automatic logic [17:0] log_at(input int i);
        if (i < log_q.size()) return log_q[i];
        return 18'h3FFFF;
    endfunction

    task automatic wait_log(input int n);
        int cyc;
        cyc = 0;
        while (log_q.size() < n && cyc < 200) begin
            step(1);
            cyc++;
        end
        chk("accept_timeout", 32'(log_q.size() >= n), 32'h1);
    endtask

    task automatic pulse_done();
        core_done = 1'b1;
        step(1);
        core_done = 1'b0;
    endtask

    task automatic drain(input int n);
        instr_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            wait_log(log_q.size() + 1);
            step(3);
            pulse_done();
        end
    endtask

    int found;

    initial begin
        reset = 1'b1; send = 1'b0; switches = '0;
        instr_ready = 1'b0; core_done = 1'b0; lcd_busy = 1'b0;
        step(3);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", 32'(instr), 32'h0);
        chk("rst_count", 32'(fifo_count), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_issued", 32'(issued_count), 32'h0);
        reset = 1'b0;
        step(2);

        // single instruction, then WAIT_DONE holds until core_done
        instr_ready = 1'b1;
        valid_cycles = 0;
        press(18'h0A5F3);
        chk("single_valid_cycles", 32'(valid_cycles), 32'h1);
        chk("single_issued", 32'(issued_count), 32'h1);
        chk("single_word", 32'(log_at(0)), 32'h0A5F3);
        press(18'h30042);
        chk("wait_count", 32'(fifo_count), 32'h1);
        chk("wait_valid", 32'(instr_valid), 32'h0);
        pulse_done();
        chk("done_plus1_valid", 32'(instr_valid), 32'h0);
        step(1);
        chk("done_plus2_valid", 32'(instr_valid), 32'h1);
        chk("done_plus2_instr", 32'(instr), 32'h30042);
        step(1);
        pulse_done();
        chk("clear_issued", 32'(issued_count), 32'h2);

        // ordering under backpressure
        instr_ready = 1'b0;
        press(18'h01111);
        press(18'h02222);
        press(18'h03333);
        chk("order_count", 32'(fifo_count), 32'h3);
        chk("order_head", 32'(instr), 32'h01111);
        drain(3);
        chk("order_0", 32'(log_at(2)), 32'h01111);
        chk("order_1", 32'(log_at(3)), 32'h02222);
        chk("order_2", 32'(log_at(4)), 32'h03333);

        // overflow
        instr_ready = 1'b0;
        press(18'h3800A);
        press(18'h00004);
        press(18'h00005);
        press(18'h00006);
        press(18'h00007);
        chk("ovf_full", 32'(full), 32'h1);
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_count", 32'(fifo_count), 32'h4);
        drain(4);
        found = 0;
        foreach (log_q[i]) if (log_q[i] == 18'h00007) found = 1;
        chk("ovf_fifth_absent", 32'(found), 32'h0);
        chk("ovf_display_word", 32'(log_at(5)), 32'h3800A);
        chk("ovf_issued", 32'(issued_count), 32'h9);

        // short glitch, then LCD gate
        instr_ready = 1'b0;
        lcd_busy = 1'b1;
        switches = 18'h15555;
        send = 1'b1;
        step(10);
        send = 1'b0;
        step(30);
        chk("glitch_count", 32'(fifo_count), 32'h0);
        press(18'h2AAAA);
        step(5);
        chk("lcd_count", 32'(fifo_count), 32'h1);
        chk("lcd_blocked", 32'(instr_valid), 32'h0);
        lcd_busy = 1'b0;
        chk("lcd_fall_same", 32'(instr_valid), 32'h0);
        step(1);
        chk("lcd_fall_plus1", 32'(instr_valid), 32'h1);
        chk("lcd_instr", 32'(instr), 32'h2AAAA);
        lcd_busy = 1'b1;
        step(3);
        chk("lcd_no_retract", 32'(instr_valid), 32'h1);
        instr_ready = 1'b1;
        step(1);
        lcd_busy = 1'b0;
        pulse_done();
        chk("lcd_issued", 32'(issued_count), 32'hA);

        // reset while an instruction is offered
        instr_ready = 1'b0;
        press(18'h11111);
        press(18'h12222);
        chk("pre_rst_valid", 32'(instr_valid), 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(instr_valid), 32'h0);
        chk("mid_rst_instr", 32'(instr), 32'h0);
        chk("mid_rst_count", 32'(fifo_count), 32'h0);
        chk("mid_rst_full", 32'(full), 32'h0);
        chk("mid_rst_overflow", 32'(overflow), 32'h0);
        chk("mid_rst_issued", 32'(issued_count), 32'h0);
        step(2);
        reset = 1'b0;
        instr_ready = 1'b1;
        step(20);
        chk("post_rst_issued", 32'(issued_count), 32'h0);
        chk("post_rst_count", 32'(fifo_count), 32'h0);
        chk("post_rst_log", 32'(log_q.size()), 32'hA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/instr_scheduler.md
# instr_scheduler

Front-end sequencer for the mini CPU datapath. Captures instruction words from the board switches on each debounced press of the send button, buffers them in a small FIFO, and issues them one at a time to the CPU core over a valid/ready handshake. The next instruction is not issued until the core reports completion and the LCD driver is idle. This lets the operator queue several instructions ahead of execution.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; must be a power of two, at least 2.
- DEBOUNCE_CYC, 16: cycles the synchronized button level must hold a new value before it is accepted. Use 16 in simulation and 500000 on the board.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high. Clears all state.
- send  in  1  raw send-button level; a press is a debounced 0→1 transition.
- switches  in  18  instruction word; [17:15] is the opcode.
- instr  out  18  instruction at the FIFO head, presented to the core.
- instr_valid  out  1  instr is valid for issue.
- instr_ready  in  1  core can accept an instruction (core in IDLE).
- core_done  in  1  one-cycle pulse from the core when the issued instruction has finished its LCD update.
- lcd_busy  in  1  LCD driver is busy; blocks new issue.
- fifo_count  out  log2(DEPTH)+1  number of queued entries.
- full  out  1  fifo_count == DEPTH.
- overflow  out  1  sticky; a press was dropped because the FIFO was full.
- issued_count  out  8  number of instructions accepted by the core; wraps 255→0.

## Operation
- Button path:
  - send passes through a 2-flop synchronizer.
  - A counter increments while the synchronized level differs from the debounced level. It clears whenever they agree.
  - When the counter reaches DEBOUNCE_CYC, the debounced level flips and the counter clears.
  - A 0→1 flip of the debounced level produces a single-cycle push pulse.
- FIFO:
  - Circular buffer with wrapping read and write pointers.
  - On push, switches is written at the tail.
  - A push succeeds if count < DEPTH, or if a pop occurs in the same cycle. Otherwise the entry is dropped and overflow is set.
  - A simultaneous push and pop leaves count unchanged.
- Issue FSM states:
  - IDLE: instr_valid = 0. Moves to ISSUE when count > 0 and lcd_busy = 0.
  - ISSUE: instr_valid = 1 and instr = head entry. When instr_valid and instr_ready are both high at a clock edge: pop, increment issued_count, move to WAIT_DONE.
  - WAIT_DONE: instr_valid = 0. Moves to IDLE on core_done.
- Handshake rules:
  - Once raised, instr_valid stays high and instr stays stable until accepted.
  - lcd_busy rising while in ISSUE does not retract instr_valid.
  - core_done in IDLE or ISSUE is ignored.
- Opcodes are not interpreted. CLEAR (110) and DISPLAY (111) are queued and issued like any other instruction.
- Asserting reset at any point, including in ISSUE or WAIT_DONE, empties the FIFO, returns to IDLE and clears overflow. Any in-flight instruction is abandoned.

## Timing
- Reset values: instr = 0, instr_valid = 0, fifo_count = 0, full = 0, overflow = 0, issued_count = 0. Debounced level = 0, debounce counter = 0, FSM = IDLE.
- With send held high from edge 0: push pulse at edge DEBOUNCE_CYC+2; fifo_count increments after edge DEBOUNCE_CYC+3.
- Glitches on send shorter than DEBOUNCE_CYC cycles produce no push.
- Empty FIFO, push, lcd_busy = 0: instr_valid rises 1 cycle after fifo_count becomes 1 (IDLE→ISSUE takes one edge).
- Acceptance edge to instr_valid low: 1 cycle.
- core_done to the next instr_valid, with more entries queued and LCD idle: 2 cycles (WAIT_DONE→IDLE→ISSUE).
- fifo_count, full and overflow are registered and update on the edge after the event that changes them.

## Test plan
- Reset mid-ISSUE:
  - Stimulus: queue 2 entries, assert reset while instr_valid = 1.
  - Required: every output returns to 0 on the next edge or earlier; no issue after reset is released.
- Single instruction:
  - Stimulus: switches = 18'h0A5F3, press send, instr_ready = 1.
  - Required: instr = 18'h0A5F3 with instr_valid high for exactly 1 cycle; issued_count = 1; FSM waits in WAIT_DONE until core_done.
- Ordering and backpressure:
  - Stimulus: queue 3 words 0x01111, 0x02222, 0x03333 with instr_ready = 0.
  - Required: fifo_count = 3. After ready rises, issue order is 0x01111, 0x02222, 0x03333, each only after core_done.
- Overflow:
  - Stimulus: 5 presses with DEPTH = 4 and no issue.
  - Required: full = 1, overflow = 1, fifo_count = 4; the 5th word never appears on instr.
- Debounce and LCD gate:
  - Stimulus: send pulse of 10 cycles, then hold lcd_busy = 1 with 1 entry queued.
  - Required: the 10-cycle pulse produces no push. instr_valid stays 0 until lcd_busy falls, then rises 1 cycle later.
